sm_mem_ctrl: RTL and testbench
==============================

SM_MEM_CTRL -- requirements
Module: sm_mem_ctrl

Interface
REQ-001 SHALL have parameter N_CORES, default 8, number of SP core lanes served.
REQ-002 SHALL have parameter AW, default 16, address width.
REQ-003 SHALL have parameter DW, default 16, data width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port MRead  input  1  level read request from SM, all enabled lanes.
REQ-007 SHALL have port MWrite  input  1  level write request from SM, all enabled lanes.
REQ-008 SHALL have port en  input  N_CORES  lane enable mask; bit i set means lane i participates.
REQ-009 SHALL have port addr  input  N_CORES*AW  per-lane address; lane i at bits [i*AW +: AW].
REQ-010 SHALL have port data  input  N_CORES*DW  per-lane write data, same packing.
REQ-011 SHALL have port q  output  N_CORES*DW  per-lane read data, registered, same packing.
REQ-012 SHALL have port MReady  output  1  operation complete.
REQ-013 SHALL have ports mem_addr  output  AW, mem_wdata  output  DW, mem_we  output  1, mem_re  output  1: single-port memory request.
REQ-014 SHALL have port mem_rdata  input  DW  memory read data, valid exactly one cycle after mem_re.

Function
REQ-015 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-016 In IDLE, when MRead or MWrite is sampled high: latch en, addr, data and op (MRead has priority if both high); go to ISSUE if latched mask nonzero, else DONE.
REQ-017 In ISSUE, one enabled lane per cycle in ascending index order; disabled lanes skipped with zero cycles of cost.
REQ-018 Write op: mem_we=1, mem_addr/mem_wdata from the current lane's latched values; after last enabled lane go to DONE.
REQ-019 Read op: mem_re=1, mem_addr from the current lane; mem_rdata captured into q of that lane on the following edge; after last lane issue go to DRAIN.
REQ-020 DRAIN captures the final read word; then DONE.
REQ-021 In DONE, MReady=1 and held until MRead and MWrite are both sampled low; then IDLE (four-phase handshake).
REQ-022 Latency, m enabled lanes, request sampled at edge 0: read MReady high at cycle m+2; write at cycle m+1; empty mask at cycle 1.
REQ-023 mem_we and mem_re never both high; both low outside ISSUE.
REQ-024 q of disabled or write-op lanes SHALL hold its previous value.
REQ-025 Duplicate write addresses across lanes: higher lane index wins (issued last).
REQ-026 Input changes on en/addr/data after latch SHALL have no effect until next IDLE acceptance.

Reset
REQ-027 Reset SHALL force state IDLE, MReady=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, all q lanes=0.
REQ-028 Reset asserted mid-operation SHALL abort immediately; no further memory access issued; a request still high after reset release is accepted as new.

Structure
REQ-029 Package sm_mem_pkg SHALL hold N_CORES, AW, DW defaults and the state enum.
REQ-030 Sub-module sm_lane_pick SHALL be a combinational priority encoder returning the lowest set bit of the remaining mask plus a valid flag.

Verification
REQ-031 All 8 lanes enabled, MWrite, addr[i]=0x10+i, data[i]=0xA0+i -> mem_we on 8 consecutive cycles, addr 0x10..0x17; MReady at cycle 9.
REQ-032 Preload mem[0x10+i]=0xA0+i; en=0xFF, MRead -> q[i]=0xA0+i; MReady at cycle 10; held until MRead low, then IDLE.
REQ-033 en=0x81, MRead -> reads lane 0 then lane 7 on consecutive cycles; q[1..6] unchanged; MReady at cycle 4.
REQ-034 en=0x00, MWrite -> no memory access; MReady at cycle 1.
REQ-035 en=0x05, MWrite, both lanes addr 0x20, data 0x1111/0x2222 -> mem[0x20]=0x2222.
REQ-036 Reset at cycle 3 of an 8-lane read -> MReady=0, mem_re=0, q all 0 next cycle; held MRead restarts full operation.

Source files
------------

// File: rtl/sm_mem_pkg.sv
`default_nettype none
// sm_mem_pkg: shared defaults, FSM state type and index-width helper for sm_mem_ctrl (rev 1.0)
package sm_mem_pkg;

  localparam int DEF_N_CORES = 8;
  localparam int DEF_AW      = 16;
  localparam int DEF_DW      = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Lane index width, kept at least one bit so a single-lane build still elaborates
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sm_mem_ctrl_if.sv
`default_nettype none
// sm_mem_ctrl_if: SM-side lane bus plus single-port memory request/response (rev 1.0)
interface sm_mem_ctrl_if
  import sm_mem_pkg::*;
#(
  parameter int N_CORES = DEF_N_CORES,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW
);

  logic                   MRead;
  logic                   MWrite;
  logic [N_CORES-1:0]     en;
  logic [N_CORES*AW-1:0]  addr;
  logic [N_CORES*DW-1:0]  data;
  logic [N_CORES*DW-1:0]  q;
  logic                   MReady;
  logic [AW-1:0]          mem_addr;
  logic [DW-1:0]          mem_wdata;
  logic                   mem_we;
  logic                   mem_re;
  logic [DW-1:0]          mem_rdata;

  modport master (
    output MRead, MWrite, en, addr, data, mem_rdata,
    input  q, MReady, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport slave (
    input  MRead, MWrite, en, addr, data, mem_rdata,
    output q, MReady, mem_addr, mem_wdata, mem_we, mem_re
  );

endinterface
`default_nettype wire

// File: rtl/sm_lane_pick.sv
`default_nettype none
// sm_lane_pick: combinational priority encoder, lowest set bit of the mask plus valid (rev 1.0)
module sm_lane_pick
  import sm_mem_pkg::*;
#(
  parameter int N  = DEF_N_CORES,
  parameter int LW = idx_width(N)
) (
  input  logic [N-1:0]  mask,
  output logic [LW-1:0] idx,
  output logic          valid
);

  // Scan downward so the lowest set bit is the last one written
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx   = LW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sm_mem_ctrl.sv
`default_nettype none
// sm_mem_ctrl: serialises per-lane SM read/write requests onto one single-port memory (rev 1.0)
module sm_mem_ctrl
  import sm_mem_pkg::*;
#(
  parameter int N_CORES = DEF_N_CORES,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  sm_mem_ctrl_if.slave  bus
);

  localparam int LW = idx_width(N_CORES);

  state_t                 state;
  state_t                 state_nxt;
  logic                   op_read;
  logic [N_CORES-1:0]     remain;
  logic [N_CORES-1:0]     remain_nxt;
  logic [N_CORES*AW-1:0]  lat_addr;
  logic [N_CORES*DW-1:0]  lat_data;
  logic [N_CORES*DW-1:0]  q_r;
  logic                   pend_valid;
  logic [LW-1:0]          pend_lane;
  logic [LW-1:0]          pick_idx;
  logic                   pick_valid;
  logic                   accept;
  logic                   ready;
  logic                   we;
  logic                   re;
  logic [AW-1:0]          maddr;
  logic [DW-1:0]          wdata;

  sm_lane_pick #(.N(N_CORES), .LW(LW)) u_pick (
    .mask  (remain),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign accept = (state == IDLE) && (bus.MRead || bus.MWrite);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_read    <= 1'b0;
      remain     <= '0;
      lat_addr   <= '0;
      lat_data   <= '0;
      q_r        <= '0;
      pend_valid <= 1'b0;
      pend_lane  <= '0;
    end else begin
      state <= state_nxt;
      // Read data returns one cycle after issue, so remember which lane it belongs to
      pend_valid <= (state == ISSUE) && op_read && pick_valid;
      pend_lane  <= pick_idx;
      if (pend_valid) begin
        q_r[pend_lane*DW +: DW] <= bus.mem_rdata;
      end
      if (accept) begin
        op_read  <= bus.MRead;
        remain   <= bus.en;
        lat_addr <= bus.addr;
        lat_data <= bus.data;
      end else if (state == ISSUE) begin
        remain <= remain_nxt;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    we         = 1'b0;
    re         = 1'b0;
    maddr      = '0;
    wdata      = '0;
    remain_nxt = remain;
    if (pick_valid) begin
      remain_nxt[pick_idx] = 1'b0;
    end

    case (state)
      IDLE: begin
        if (bus.MRead || bus.MWrite) begin
          state_nxt = (bus.en != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        maddr = lat_addr[pick_idx*AW +: AW];
        if (op_read) begin
          re = pick_valid;
        end else begin
          we    = pick_valid;
          wdata = lat_data[pick_idx*DW +: DW];
        end
        if (remain_nxt == '0) begin
          state_nxt = op_read ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        state_nxt = DONE;
      end
      DONE: begin
        ready = 1'b1;
        if (!bus.MRead && !bus.MWrite) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.q         = q_r;
  assign bus.MReady    = ready;
  assign bus.mem_we    = we;
  assign bus.mem_re    = re;
  assign bus.mem_addr  = maddr;
  assign bus.mem_wdata = wdata;

endmodule
`default_nettype wire

// File: tb/tb_sm_mem_ctrl.sv
`default_nettype none
// tb_sm_mem_ctrl: scoreboard bench with a lane-level reference model and a small memory (rev 1.0)
module tb_sm_mem_ctrl;

  typedef struct {
    bit          wr;
    logic [15:0] a;
    logic [15:0] d;
    int          rel;
  } acc_t;

  typedef struct {
    int           cyc;
    logic [127:0] q;
  } done_t;

  logic clk;
  logic rst;
  bit   wipe;
  int   cyc;
  int   req_cyc;
  int   n_cmp;
  int   n_fail;
  bit   prev_ready;

  acc_t        acc_q[$];
  done_t       done_q[$];
  acc_t        mon_e;
  done_t       mon_c;
  logic [15:0] ref_mem [0:255];
  logic [15:0] ref_q   [0:7];
  logic [15:0] env_mem [0:255];

  sm_mem_ctrl_if #(.N_CORES(8), .AW(16), .DW(16)) bif ();

  sm_mem_ctrl #(.N_CORES(8), .AW(16), .DW(16)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Environment memory: registered read, one cycle after mem_re
  always @(posedge clk) begin
    if (wipe) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= '0;
      bif.mem_rdata <= '0;
    end else begin
      if (bif.mem_we) env_mem[bif.mem_addr[7:0]] <= bif.mem_wdata;
      if (bif.mem_re) bif.mem_rdata <= env_mem[bif.mem_addr[7:0]];
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expected accesses and completions as the DUT presents them
  always @(negedge clk) begin
    check("we_re_exclusive", 128'(bif.mem_we & bif.mem_re), 128'd0);
    if (bif.mem_we || bif.mem_re) begin
      check("access_expected", 128'(acc_q.size() != 0), 128'd1);
      if (acc_q.size() != 0) begin
        mon_e = acc_q.pop_front();
        check("acc_kind", 128'(bif.mem_we), 128'(mon_e.wr));
        check("acc_addr", 128'(bif.mem_addr), 128'(mon_e.a));
        if (mon_e.wr) check("acc_wdata", 128'(bif.mem_wdata), 128'(mon_e.d));
        check("acc_cycle", 128'(cyc - req_cyc), 128'(mon_e.rel));
      end
    end
    if (bif.MReady && !prev_ready) begin
      check("done_expected", 128'(done_q.size() != 0), 128'd1);
      if (done_q.size() != 0) begin
        mon_c = done_q.pop_front();
        check("ready_cycle", 128'(cyc - req_cyc), 128'(mon_c.cyc));
        check("q_value", bif.q, mon_c.q);
      end
    end
    prev_ready = bif.MReady;
  end

  // Drive a request and compute its expected effects from lane-level rules
  task automatic issue(input bit rd, input bit wr, input logic [7:0] m,
                       input logic [127:0] a, input logic [127:0] d);
    int          k;
    acc_t        e;
    done_t       c;
    logic [15:0] ad;
    logic [15:0] dd;
    bif.MRead  = rd;
    bif.MWrite = wr;
    bif.en     = m;
    bif.addr   = a;
    bif.data   = d;
    req_cyc    = cyc;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        ad    = a[i*16 +: 16];
        dd    = d[i*16 +: 16];
        e.wr  = !rd;
        e.a   = ad;
        e.d   = dd;
        e.rel = k + 1;
        acc_q.push_back(e);
        k++;
        if (rd) ref_q[i] = ref_mem[ad[7:0]];
        else    ref_mem[ad[7:0]] = dd;
      end
    end
    c.cyc = (k == 0) ? 1 : (rd ? k + 2 : k + 1);
    for (int i = 0; i < 8; i++) c.q[i*16 +: 16] = ref_q[i];
    done_q.push_back(c);
  endtask

  task automatic finish_op(input bit scramble);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (scramble) begin
        bif.en   = 8'($urandom);
        bif.addr = {$urandom, $urandom, $urandom, $urandom};
        bif.data = {$urandom, $urandom, $urandom, $urandom};
      end
    end while (!bif.MReady && n < 100);
    if (!bif.MReady) check("ready_timeout", 128'(bif.MReady), 128'd1);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check("ready_held", 128'(bif.MReady), 128'd1);
    end
    bif.MRead  = 1'b0;
    bif.MWrite = 1'b0;
    @(negedge clk);
    check("ready_released", 128'(bif.MReady), 128'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [127:0] av;
    logic [127:0] dv;
    logic [7:0]   m;
    int           r;
    n_cmp = 0;
    n_fail = 0;
    cyc = 0;
    req_cyc = 0;
    prev_ready = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    for (int i = 0; i < 8; i++) ref_q[i] = '0;
    rst = 1'b1;
    wipe = 1'b1;
    bif.MRead = 1'b0;
    bif.MWrite = 1'b0;
    bif.en = '0;
    bif.addr = '0;
    bif.data = '0;
    repeat (3) @(negedge clk);
    check("rst_mready", 128'(bif.MReady), 128'd0);
    check("rst_mem_we", 128'(bif.mem_we), 128'd0);
    check("rst_mem_re", 128'(bif.mem_re), 128'd0);
    check("rst_mem_addr", 128'(bif.mem_addr), 128'd0);
    check("rst_mem_wdata", 128'(bif.mem_wdata), 128'd0);
    check("rst_q", bif.q, 128'd0);
    rst = 1'b0;
    wipe = 1'b0;
    @(negedge clk);

    // Eight-lane write, then read back the same addresses
    for (int i = 0; i < 8; i++) begin
      av[i*16 +: 16] = 16'h0010 + 16'(i);
      dv[i*16 +: 16] = 16'h00A0 + 16'(i);
    end
    issue(1'b0, 1'b1, 8'hFF, av, dv);
    finish_op(1'b1);
    issue(1'b1, 1'b0, 8'hFF, av, dv);
    finish_op(1'b1);

    // Sparse mask: lanes 0 and 7 only; other lanes point at zero memory
    av = '0;
    av[0*16 +: 16] = 16'h0017;
    av[7*16 +: 16] = 16'h0010;
    issue(1'b1, 1'b0, 8'h81, av, dv);
    finish_op(1'b0);

    // Empty mask
    issue(1'b0, 1'b1, 8'h00, av, dv);
    finish_op(1'b0);

    // Same address on lanes 0 and 2
    av = '0;
    dv = '0;
    av[0*16 +: 16] = 16'h0020;
    av[2*16 +: 16] = 16'h0020;
    dv[0*16 +: 16] = 16'h1111;
    dv[2*16 +: 16] = 16'h2222;
    issue(1'b0, 1'b1, 8'h05, av, dv);
    finish_op(1'b0);
    check("dup_write_winner", 128'(env_mem[8'h20]), 128'h2222);

    // Reset in cycle 3 of an eight-lane read, request kept high across it
    for (int i = 0; i < 8; i++) begin
      av[i*16 +: 16] = 16'h0010 + 16'(i);
      dv[i*16 +: 16] = '0;
    end
    issue(1'b1, 1'b0, 8'hFF, av, dv);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_mready", 128'(bif.MReady), 128'd0);
    check("abort_mem_re", 128'(bif.mem_re), 128'd0);
    check("abort_mem_we", 128'(bif.mem_we), 128'd0);
    check("abort_q", bif.q, 128'd0);
    acc_q.delete();
    done_q.delete();
    for (int i = 0; i < 8; i++) ref_q[i] = '0;
    rst = 1'b0;
    issue(1'b1, 1'b0, 8'hFF, av, dv);
    finish_op(1'b0);

    // Randomised operations over a small address window to force collisions
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 7);
      m = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
      for (int i = 0; i < 8; i++) begin
        av[i*16 +: 16] = 16'($urandom_range(0, 31));
        dv[i*16 +: 16] = 16'($urandom);
      end
      r = $urandom_range(0, 3);
      issue(r == 1 || r == 2, r != 1, m, av, dv);
      finish_op($urandom_range(0, 1) == 1);
    end

    check("acc_queue_drained", 128'(acc_q.size()), 128'd0);
    check("done_queue_drained", 128'(done_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
